// File: rtl/flat_shader_fx.sv
// Flat-shading unit: edges -> face normal -> optional back-face cull -> N.L -> saturated intensity.
// Latency: done 2*MUL_LAT+12 cycles after accept, MUL_LAT+9 when culled; one job in flight.
// Backpressure: start is ignored while a job is running; next job may be accepted in the done cycle.
module flat_shader_fx #(
    parameter int COORD_W = 16,
    parameter int COLOR_W = 4,
    parameter int MUL_LAT = 2,
    parameter int SHIFT   = 41,
    parameter int AMBIENT = 1
) (
    input  logic                     clk,
    input  logic                     sreset,
    input  logic                     start,
    input  logic                     cull_en,
    input  logic [2:0][COORD_W-1:0]  p1,
    input  logic [2:0][COORD_W-1:0]  p2,
    input  logic [2:0][COORD_W-1:0]  p3,
    input  logic [2:0][COORD_W-1:0]  light,
    output logic                     busy,
    output logic                     done,
    output logic [COLOR_W-1:0]       color,
    output logic                     culled
);

    // Edge, normal, dot-sum and multiplier widths; all exact for full-range inputs.
    localparam int EW = COORD_W + 1;
    localparam int NW = 2*COORD_W + 3;
    localparam int DW = 3*COORD_W + 5;
    localparam int PW = NW + EW;

    localparam logic [7:0] CROSS_LAST = 8'(6 + MUL_LAT - 1);
    localparam logic [7:0] DOT_LAST   = 8'(3 + MUL_LAT - 1);
    localparam logic [7:0] MUL_L8     = 8'(MUL_LAT);

    localparam logic signed [DW-1:0] AMB_S = DW'(AMBIENT);
    localparam logic signed [DW-1:0] MAX_S = DW'((1 << COLOR_W) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EDGE,
        S_CROSS,
        S_CULLCHK,
        S_DOT,
        S_SHADE
    } state_t;

    state_t state;
    state_t state_nxt;
    logic [7:0] cnt;
    logic       accept;

    logic [2:0][COORD_W-1:0] p1_q;
    logic [2:0][COORD_W-1:0] p2_q;
    logic [2:0][COORD_W-1:0] p3_q;
    logic [2:0][COORD_W-1:0] light_q;
    logic                    cull_q;

    logic signed [EW-1:0] e1 [3];
    logic signed [EW-1:0] e2 [3];
    logic signed [NW-1:0] n  [3];
    logic signed [DW-1:0] d;
    logic                 cull_flag;
    logic                 cull_hit;

    logic signed [NW-1:0] mul_a;
    logic signed [EW-1:0] mul_b;
    logic signed [PW-1:0] prod_pipe [MUL_LAT];
    logic signed [PW-1:0] prod_out;
    logic [7:0]           arr;

    logic signed [DW-1:0] shade_i;
    logic [COLOR_W-1:0]   shade_col;

    assign accept   = (state == S_IDLE) && start;
    assign busy     = (state != S_IDLE) || done;
    assign cull_hit = cull_q && (n[2][NW-1] || (n[2] == '0));
    assign prod_out = prod_pipe[MUL_LAT-1];
    assign arr      = cnt - MUL_L8;

    // State register; reset wins over everything, including a coincident start.
    always_ff @(posedge clk) begin
        if (sreset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; CROSS and DOT dwell long enough for the last product to drain.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_EDGE;
            S_EDGE:    state_nxt = S_CROSS;
            S_CROSS:   if (cnt == CROSS_LAST) state_nxt = S_CULLCHK;
            S_CULLCHK: state_nxt = cull_hit ? S_SHADE : S_DOT;
            S_DOT:     if (cnt == DOT_LAST) state_nxt = S_SHADE;
            S_SHADE:   state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Per-state cycle counter, restarted on every state change.
    always_ff @(posedge clk) begin
        if (sreset || (state_nxt != state) || (state == S_IDLE)) cnt <= '0;
        else                                                     cnt <= cnt + 8'd1;
    end

    // Operand select for the shared multiplier: six cross terms, then three N.L terms.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (state == S_CROSS) begin
            case (cnt)
                8'd0: begin mul_a = NW'(e1[1]); mul_b = e2[2]; end
                8'd1: begin mul_a = NW'(e1[2]); mul_b = e2[1]; end
                8'd2: begin mul_a = NW'(e1[2]); mul_b = e2[0]; end
                8'd3: begin mul_a = NW'(e1[0]); mul_b = e2[2]; end
                8'd4: begin mul_a = NW'(e1[0]); mul_b = e2[1]; end
                8'd5: begin mul_a = NW'(e1[1]); mul_b = e2[0]; end
                default: ;
            endcase
        end else if (state == S_DOT) begin
            case (cnt)
                8'd0: begin mul_a = n[0]; mul_b = EW'($signed(light_q[0])); end
                8'd1: begin mul_a = n[1]; mul_b = EW'($signed(light_q[1])); end
                8'd2: begin mul_a = n[2]; mul_b = EW'($signed(light_q[2])); end
                default: ;
            endcase
        end
    end

    // Multiplier pipeline: product registered, then MUL_LAT-1 delay stages.
    always_ff @(posedge clk) begin
        if (sreset) begin
            for (int i = 0; i < MUL_LAT; i++) prod_pipe[i] <= '0;
        end else begin
            prod_pipe[0] <= PW'(mul_a) * PW'(mul_b);
            for (int i = 1; i < MUL_LAT; i++) prod_pipe[i] <= prod_pipe[i-1];
        end
    end

    // Intensity mapping: clamp below at AMBIENT and above at full scale.
    always_comb begin
        shade_i = d >>> SHIFT;
        if (shade_i <= AMB_S)      shade_col = COLOR_W'(AMBIENT);
        else if (shade_i >= MAX_S) shade_col = '1;
        else                       shade_col = shade_i[COLOR_W-1:0];
    end

    // Datapath: latch job, form edges, accumulate normal and dot sum, publish result.
    always_ff @(posedge clk) begin
        if (sreset) begin
            p1_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            light_q   <= '0;
            cull_q    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                e1[k] <= '0;
                e2[k] <= '0;
                n[k]  <= '0;
            end
            d         <= '0;
            cull_flag <= 1'b0;
            done      <= 1'b0;
            color     <= '0;
            culled    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        p1_q      <= p1;
                        p2_q      <= p2;
                        p3_q      <= p3;
                        light_q   <= light;
                        cull_q    <= cull_en;
                        cull_flag <= 1'b0;
                        color     <= '0;
                        culled    <= 1'b0;
                    end
                end
                S_EDGE: begin
                    for (int k = 0; k < 3; k++) begin
                        e1[k] <= EW'($signed(p2_q[k])) - EW'($signed(p1_q[k]));
                        e2[k] <= EW'($signed(p3_q[k])) - EW'($signed(p1_q[k]));
                    end
                end
                S_CROSS: begin
                    if (cnt >= MUL_L8) begin
                        case (arr)
                            8'd0: n[0] <= $signed(prod_out[NW-1:0]);
                            8'd1: n[0] <= n[0] - $signed(prod_out[NW-1:0]);
                            8'd2: n[1] <= $signed(prod_out[NW-1:0]);
                            8'd3: n[1] <= n[1] - $signed(prod_out[NW-1:0]);
                            8'd4: n[2] <= $signed(prod_out[NW-1:0]);
                            8'd5: n[2] <= n[2] - $signed(prod_out[NW-1:0]);
                            default: ;
                        endcase
                    end
                end
                S_CULLCHK: begin
                    cull_flag <= cull_hit;
                    d         <= '0;
                end
                S_DOT: begin
                    if (cnt >= MUL_L8) d <= d + DW'(prod_out);
                end
                S_SHADE: begin
                    done <= 1'b1;
                    if (cull_flag) begin
                        color  <= '0;
                        culled <= 1'b1;
                    end else begin
                        color  <= shade_col;
                        culled <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
